// File: rtl/alu_control_seq_if.sv
// ---------------------------------------------------------------------------
// alu_control_seq_if
//   Request/response bundle between the main control unit (master) and the
//   ALU control sequencer (slave).
//
//   Request side (master drives):
//     In_valid     decode request
//     ALU_Op       2-bit class from the main decoder
//     Function     R-type funct field
//     Flush        cancel an in-flight MUL/DIV, or drop the request in IDLE
//   Response side (slave drives):
//     In_ready     request accepted when In_valid & In_ready
//     ALU_control  registered ALU operation code (CTRL_W bits)
//     Ctrl_valid   one-cycle pulse per accepted request
//     Md_start     one-cycle pulse when a MUL/DIV is launched
//     Md_done      one-cycle pulse on the last MUL/DIV busy cycle
//     Illegal      unknown-funct trap flag (tied low unless the trap is built)
// ---------------------------------------------------------------------------
interface alu_control_seq_if #(
  parameter int CTRL_W = 4
);
  logic              In_valid;
  logic              In_ready;
  logic [1:0]        ALU_Op;
  logic [5:0]        Function;
  logic              Flush;
  logic [CTRL_W-1:0] ALU_control;
  logic              Ctrl_valid;
  logic              Md_start;
  logic              Md_done;
  logic              Illegal;

  modport master (
    output In_valid,
    output ALU_Op,
    output Function,
    output Flush,
    input  In_ready,
    input  ALU_control,
    input  Ctrl_valid,
    input  Md_start,
    input  Md_done,
    input  Illegal
  );

  modport slave (
    input  In_valid,
    input  ALU_Op,
    input  Function,
    input  Flush,
    output In_ready,
    output ALU_control,
    output Ctrl_valid,
    output Md_start,
    output Md_done,
    output Illegal
  );
endinterface

// File: rtl/alu_control_seq.sv
// ---------------------------------------------------------------------------
// alu_control_seq
//   Registered ALU control decoder with a valid/ready handshake and a
//   multi-cycle sequencer for MULT/DIV.  Sits between the main control unit
//   and the ALU / mul-div datapath.
//
//   Ports:
//     clk       rising-edge clock
//     reset_n   asynchronous active-low reset
//     ctrl_bus  alu_control_seq_if.slave (handshake, decode inputs, outputs)
//
//   Parameters:
//     CTRL_W      ALU_control width (>= 4); codes are zero-extended
//     MUL_CYCLES  busy cycles for MULT/MULTU (>= 1)
//     DIV_CYCLES  busy cycles for DIV/DIVU (>= 1)
//     CNT_W       busy counter width; 2**CNT_W > max(MUL_CYCLES, DIV_CYCLES)
//
//   Build option:
//     ALU_ILLEGAL_TRAP_EN  when defined, an accepted unknown R-type funct sets
//                          a sticky Illegal flag (cleared by reset or by the
//                          next accepted legal op).  When undefined, Illegal
//                          is tied low and unknown functs decode to NOP.
// ---------------------------------------------------------------------------
module alu_control_seq #(
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  alu_control_seq_if.slave  ctrl_bus
);

  // ALU operation codes (4-bit, zero-extended to CTRL_W on output)
  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;
  localparam logic [3:0] OP_NOP  = 4'd15;

  // Counter load values: the counter counts the remaining busy cycles after
  // the current one, so a load of CYCLES-1 yields exactly CYCLES busy cycles.
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [CTRL_W-1:0] alu_control_reg;
  logic              ctrl_valid_reg;
  logic              md_start_reg;

  logic [3:0]        dec_op;
  logic              dec_md;
  logic              dec_div;
  logic              in_ready;
  logic              accept;
  logic              md_last;

  // -------------------------------------------------------------------------
  // Combinational decode of the request currently on the bus
  // -------------------------------------------------------------------------
  always_comb begin
    dec_op  = OP_NOP;
    dec_md  = 1'b0;
    dec_div = 1'b0;
    case (ctrl_bus.ALU_Op)
      2'd0: dec_op = OP_ADD;
      2'd1: dec_op = OP_SUB;
      2'd3: dec_op = OP_OR;
      default: begin
        case (ctrl_bus.Function)
          6'd32, 6'd33: dec_op = OP_ADD;
          6'd34, 6'd35: dec_op = OP_SUB;
          6'd36:        dec_op = OP_AND;
          6'd37:        dec_op = OP_OR;
          6'd38:        dec_op = OP_XOR;
          6'd39:        dec_op = OP_NOR;
          6'd42:        dec_op = OP_SLT;
          6'd43:        dec_op = OP_SLTU;
          6'd0:         dec_op = OP_SLL;
          6'd2:         dec_op = OP_SRL;
          6'd3:         dec_op = OP_SRA;
          6'd24, 6'd25: begin
            dec_op = OP_MUL;
            dec_md = 1'b1;
          end
          6'd26, 6'd27: begin
            dec_op  = OP_DIV;
            dec_md  = 1'b1;
            dec_div = 1'b1;
          end
          default:      dec_op = OP_NOP;
        endcase
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  assign in_ready = (state_reg == ST_IDLE);
  // Flush in IDLE swallows a simultaneous request.
  assign accept   = ctrl_bus.In_valid & in_ready & ~ctrl_bus.Flush;
  assign md_last  = (state_reg == ST_MD_BUSY) && (cnt_reg == '0);

  // -------------------------------------------------------------------------
  // Sequencer: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept && dec_md) begin
          state_next = ST_MD_BUSY;
          cnt_next   = dec_div ? DIV_LOAD : MUL_LOAD;
        end
      end
      ST_MD_BUSY: begin
        if (ctrl_bus.Flush) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequencer: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // -------------------------------------------------------------------------
  // Registered decode outputs.  ALU_control holds its value between accepts
  // so the datapath can keep using it; Ctrl_valid marks the fresh cycle.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_control_reg <= CTRL_W'(OP_NOP);
      ctrl_valid_reg  <= 1'b0;
      md_start_reg    <= 1'b0;
    end else begin
      ctrl_valid_reg <= accept;
      md_start_reg   <= accept & dec_md;
      if (accept) begin
        alu_control_reg <= CTRL_W'(dec_op);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Unknown-funct trap
  // -------------------------------------------------------------------------
`ifdef ALU_ILLEGAL_TRAP_EN
  logic dec_unknown;
  logic illegal_reg;

  // NOP is produced only by the R-type fall-through, so it marks an unknown funct.
  assign dec_unknown = (ctrl_bus.ALU_Op == 2'd2) && (dec_op == OP_NOP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_reg <= 1'b0;
    end else if (accept) begin
      // Set by an unknown funct, cleared by the next legal accept.
      illegal_reg <= dec_unknown;
    end
  end

  assign ctrl_bus.Illegal = illegal_reg;
`else
  assign ctrl_bus.Illegal = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Output drive.  Md_done is combinational from the busy count so that it
  // lands on the last busy cycle (and coincides with Md_start for a
  // one-cycle operation); a same-cycle Flush suppresses it.
  // -------------------------------------------------------------------------
  assign ctrl_bus.In_ready    = in_ready;
  assign ctrl_bus.ALU_control = alu_control_reg;
  assign ctrl_bus.Ctrl_valid  = ctrl_valid_reg;
  assign ctrl_bus.Md_start    = md_start_reg;
  assign ctrl_bus.Md_done     = md_last & ~ctrl_bus.Flush;

endmodule
